// File: rtl/fp_minmax_stream.sv
// fp_minmax_stream: two-stage FMIN/FMAX unit (IEEE-754-2008 minNum/maxNum,
// RISC-V NaN and signed-zero rules) with an accumulating reduction mode.
// S1 holds the compare/accumulate result, S2 is the output register; the
// whole pipe stalls while S2 holds an unaccepted result.
module fp_minmax_stream #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic [2:0]       rm,
    input  logic             in_red,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             nv,
    output logic [CNT_W-1:0] count
);

    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] SIGN_BIT  = {1'b1, {(W-1){1'b0}}};

    function automatic logic f_is_nan(input logic [W-1:0] x);
        return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    function automatic logic f_is_snan(input logic [W-1:0] x);
        return f_is_nan(x) && !x[MAN_W-1];
    endfunction

    // Monotone unsigned key: -0 sorts just below +0, negatives reversed.
    function automatic logic [W-1:0] f_key(input logic [W-1:0] x);
        return x[W-1] ? ~x : (x ^ SIGN_BIT);
    endfunction

    function automatic logic [W-1:0] f_minmax(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic         is_max);
        logic nx, ny, lt;
        nx = f_is_nan(x);
        ny = f_is_nan(y);
        lt = f_key(x) < f_key(y);
        if (nx && ny)   return CANON_NAN;
        else if (nx)    return y;
        else if (ny)    return x;
        else if (is_max) return lt ? y : x;
        else            return lt ? x : y;
    endfunction

    // Accumulator state (reduction only)
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_acc_nv;
    logic             r_acc_max;
    logic             r_open;

    // Pipeline registers
    logic             r_s1_valid;
    logic [W-1:0]     r_s1_res;
    logic             r_s1_nv;
    logic [CNT_W-1:0] r_s1_cnt;
    logic             r_out_valid;
    logic [W-1:0]     r_out_res;
    logic             r_out_nv;
    logic [CNT_W-1:0] r_out_cnt;

    logic             w_advance;
    logic             w_accept;
    logic             w_red_first;
    logic             w_red_max;
    logic [W-1:0]     w_pair_res;
    logic             w_pair_nv;
    logic [W-1:0]     w_red_res;
    logic [CNT_W-1:0] w_red_cnt;
    logic             w_red_nv;
    logic             w_emit;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_accept  = in_valid && w_advance;

    // A non-first beat arriving with no open reduction starts a new one.
    assign w_red_first = in_first || !r_open;
    assign w_red_max   = w_red_first ? (rm != 3'b000) : r_acc_max;
    assign w_red_res   = f_minmax(op_a, w_red_first ? op_a : r_acc, w_red_max);
    assign w_red_cnt   = w_red_first ? CNT_W'(1)
                       : ((&r_acc_cnt) ? r_acc_cnt : r_acc_cnt + CNT_W'(1));
    assign w_red_nv    = f_is_snan(op_a) || (!w_red_first && r_acc_nv);

    assign w_pair_res  = f_minmax(op_a, op_b, rm != 3'b000);
    assign w_pair_nv   = f_is_snan(op_a) || f_is_snan(op_b);

    // Only pairwise beats and the last reduction beat produce a result.
    assign w_emit = w_accept && (!in_red || in_last);

    // Accumulator: updates on every accepted reduction beat; pairwise beats leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
            r_acc_nv  <= 1'b0;
            r_acc_max <= 1'b0;
            r_open    <= 1'b0;
        end else if (w_accept && in_red) begin
            r_acc     <= w_red_res;
            r_acc_cnt <= w_red_cnt;
            r_acc_nv  <= w_red_nv;
            r_acc_max <= w_red_max;
            r_open    <= !in_last;
        end
    end

    // S1: captures the pairwise result or the finished reduction; bubble otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_res   <= '0;
            r_s1_nv    <= 1'b0;
            r_s1_cnt   <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_emit;
            if (w_emit) begin
                r_s1_res <= in_red ? w_red_res : w_pair_res;
                r_s1_nv  <= in_red ? w_red_nv  : w_pair_nv;
                r_s1_cnt <= in_red ? w_red_cnt : CNT_W'(2);
            end
        end
    end

    // S2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_nv    <= 1'b0;
            r_out_cnt   <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_res <= r_s1_res;
                r_out_nv  <= r_s1_nv;
                r_out_cnt <= r_s1_cnt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_out_res;
    assign nv        = r_out_nv;
    assign count     = r_out_cnt;

endmodule

// File: doc/fp_minmax_stream.md
# fp_minmax_stream

Parametrised, pipelined floating-point min/max unit with valid/ready handshakes and an accumulating reduction mode. It executes FMIN/FMAX with IEEE-754-2008 minNum/maxNum semantics (RISC-V F-extension NaN and signed-zero rules) on one operand pair per cycle. It can also fold a tagged stream of operands into a single min or max. It sits in the FP execute cluster beside the other FP arithmetic units and drives the FP writeback arbiter.

## Interface
- EXP_W, 8: exponent width
- MAN_W, 23: mantissa width; W = 1+EXP_W+MAN_W
- CNT_W, 16: element-count width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts beat this cycle
- op_a  in  W  first operand / reduction element
- op_b  in  W  second operand (ignored when in_red=1)
- rm  in  3  3'b000 = min, any other value = max
- in_red  in  1  beat belongs to a reduction
- in_first  in  1  first element of reduction (in_red=1 only)
- in_last  in  1  last element of reduction (in_red=1 only)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  min/max result
- nv  out  1  invalid flag: a signalling NaN was consumed
- count  out  CNT_W  elements folded into result (2 for pairwise)

## Operation
- Ordering key: sign=0 → x ^ (1<<(W-1)); sign=1 → ~x. Compare keys unsigned. This gives -0 < +0 and total order on non-NaN values.
- NaN = exp all-ones and man≠0. sNaN = NaN with man MSB 0. Canonical NaN = 0, exp all-ones, man MSB 1, remaining bits 0 (0x7FC00000 for defaults).
- minmax(x,y):
  - exactly one NaN → return the other operand;
  - both NaN → canonical NaN;
  - else → min/max by key (equal keys ⇒ identical bits).
  - nv=1 if either input is sNaN.
- Pairwise beat (in_red=0): minmax(op_a, op_b), count=2.
- Reduction beat (in_red=1):
  - in_first=1 → acc = minmax(op_a, op_a); latch rm; cnt=1; nv_acc = sNaN(op_a).
  - otherwise → acc = minmax(op_a, acc) using latched rm; cnt saturating +1 at 2^CNT_W-1; nv_acc |= sNaN(op_a).
  - Only in_last=1 produces an output (acc, cnt, nv_acc). in_first&in_last together = single-element reduction.
  - Non-first reduction beat with no open reduction: treated as in_first.
- Pairwise beats may interleave with an open reduction. Accumulator state is untouched by them, and outputs leave in acceptance order.

## Timing
- Two stages: S1 (compare/accumulate register, s1_valid) → S2 (output register, out_valid).
- advance = !out_valid || out_ready. in_ready = advance; the whole pipe stalls when S2 holds an unaccepted result.
- Latency: beat accepted in cycle t (in_valid&&in_ready) → result with out_valid high from cycle t+2, given no stall.
- Throughput: one beat per cycle; no bubbles inserted under continuous out_ready=1.
- Non-last reduction beats load s1_valid=0 (bubble); accumulator updates at the acceptance edge.
- result/nv/count are stable while out_valid=1 && out_ready=0.
- Reset (any time, including mid-reduction): out_valid=0, s1_valid=0, result=0, nv=0, count=0, accumulator cleared, reduction closed. in_ready is 1 during and after reset.
- rm/in_* are sampled only on acceptance.

## Test plan
- Pairwise min, rm=000: op_a=0x3F800000, op_b=0xC0000000 → result 0xC0000000, nv=0, count=2, out_valid at t+2.
- Signed zero: op_a=0x00000000, op_b=0x80000000. rm=001 → 0x00000000. rm=000 → 0x80000000.
- NaN cases:
  - min(0x7FC00000, 0x40400000) → 0x40400000, nv=0;
  - max(0x7F800001, 0x7FC00000) → 0x7FC00000, nv=1.
- Reduction max over 0x3F800000(first), 0x40A00000, 0xC0400000, 0x40000000(last), interleaved with a pairwise beat → pairwise result first, then exactly one reduction output 0x40A00000, count=4, nv=0.
- Backpressure: 3 back-to-back pairwise beats, out_ready=0 for 5 cycles → in_ready drops once S2 and S1 are full, no loss or reorder, held result unchanged.
- Reset mid-reduction after 2 beats → all outputs 0. Then a single-element reduction 0xBF800000 (first&last) → result 0xBF800000, count=1.
